// File: rtl/mxint8_add.sv
// Adds two MXINT8 blocks: aligns both to a common scale, sums in 24-bit, then
// renormalises the sums back to 8-bit elements. One-cycle registered latency.
module mxint8_add #(
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned ELEM_W     = 8,
  parameter int unsigned SCALE_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic        [SCALE_W-1:0] i_scale_a,
  input  logic        [SCALE_W-1:0] i_scale_b,
  input  logic signed [ELEM_W-1:0]  i_mxint8_elements_a [BLOCK_SIZE],
  input  logic signed [ELEM_W-1:0]  i_mxint8_elements_b [BLOCK_SIZE],
  output logic        [SCALE_W-1:0] o_scale,
  output logic        [ELEM_W-1:0]  o_mxint8_elements [BLOCK_SIZE],
  output logic                      o_overflow,
  output logic                      o_is_unused,
  output logic        [9:0]         normalize_shift,
  output logic signed [23:0]        temp_add_result [BLOCK_SIZE],
  output logic        [23:0]        max_abs_value,
  output logic signed [23:0]        i_mxint8_elements_a_temp [BLOCK_SIZE],
  output logic signed [23:0]        i_mxint8_elements_b_temp [BLOCK_SIZE]
);

  localparam logic [SCALE_W-1:0] SCALE_NAN   = '1;
  localparam logic [SCALE_W:0]   SCALE_LIMIT = (SCALE_W+1)'(254);

  logic        [SCALE_W-1:0] scale_hi, scale_lo, scale_floor, base;
  logic        [SCALE_W:0]   scale_sum;
  logic        [4:0]         k;
  logic                      k_found, nan_in, ovf;
  logic        [23:0]        mag, mabs;
  logic signed [23:0]        a_temp [BLOCK_SIZE];
  logic signed [23:0]        b_temp [BLOCK_SIZE];
  logic signed [23:0]        sum    [BLOCK_SIZE];
  logic signed [23:0]        shifted;
  logic        [ELEM_W-1:0]  elems_nxt [BLOCK_SIZE];
  logic        [SCALE_W-1:0] scale_nxt;

  // Align one element to the common base; right shifts are clamped at 23 so
  // far-below-base values collapse to 0 or -1.
  function automatic logic signed [23:0] align(
    input logic signed [ELEM_W-1:0]  e,
    input logic        [SCALE_W-1:0] s,
    input logic        [SCALE_W-1:0] b
  );
    logic signed [23:0]        x;
    logic        [SCALE_W-1:0] d;
    x = 24'(e);
    if (s >= b) begin
      return x <<< (s - b);
    end else begin
      d = b - s;
      if (d > SCALE_W'(23)) d = SCALE_W'(23);
      return x >>> d;
    end
  endfunction

  always_comb begin
    scale_hi    = (i_scale_a > i_scale_b) ? i_scale_a : i_scale_b;
    scale_lo    = (i_scale_a > i_scale_b) ? i_scale_b : i_scale_a;
    scale_floor = scale_hi - SCALE_W'(15);
    base        = (scale_lo > scale_floor) ? scale_lo : scale_floor;
  end

  always_comb begin
    mabs = '0;
    mag  = '0;
    for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
      a_temp[i] = align(i_mxint8_elements_a[i], i_scale_a, base);
      b_temp[i] = align(i_mxint8_elements_b[i], i_scale_b, base);
      sum[i]    = a_temp[i] + b_temp[i];
      mag       = sum[i][23] ? ~sum[i] : sum[i];
      if (mag > mabs) mabs = mag;
    end
  end

  always_comb begin
    k       = 5'd16;
    k_found = 1'b0;
    for (int unsigned j = 0; j <= 16; j++) begin
      if (!k_found && ((mabs >> j) <= 24'd127)) begin
        k       = 5'(j);
        k_found = 1'b1;
      end
    end
  end

  always_comb begin
    scale_sum = {1'b0, base} + (SCALE_W+1)'(k);
    nan_in    = (i_scale_a == SCALE_NAN) || (i_scale_b == SCALE_NAN);
    ovf       = !nan_in && (scale_sum > SCALE_LIMIT);
    scale_nxt = (nan_in || ovf) ? SCALE_NAN : scale_sum[SCALE_W-1:0];
    shifted   = '0;
    for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
      shifted      = sum[i] >>> k;
      elems_nxt[i] = (nan_in || ovf) ? '0 : shifted[ELEM_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_scale                  <= '0;
      o_mxint8_elements        <= '{default: '0};
      o_overflow               <= 1'b0;
      o_is_unused              <= 1'b0;
      normalize_shift          <= '0;
      temp_add_result          <= '{default: '0};
      max_abs_value            <= '0;
      i_mxint8_elements_a_temp <= '{default: '0};
      i_mxint8_elements_b_temp <= '{default: '0};
    end else begin
      o_scale                  <= scale_nxt;
      o_mxint8_elements        <= elems_nxt;
      o_overflow               <= ovf;
      o_is_unused              <= nan_in;
      normalize_shift          <= 10'(k);
      temp_add_result          <= sum;
      max_abs_value            <= mabs;
      i_mxint8_elements_a_temp <= a_temp;
      i_mxint8_elements_b_temp <= b_temp;
    end
  end

endmodule

// File: tb/tb_mxint8_add.sv
// Directed-vector bench for mxint8_add with hand-computed expectations.
module tb_mxint8_add;

  localparam int unsigned BS = 32;

  logic              clk;
  logic              rst;
  logic        [7:0] sa, sb;
  logic signed [7:0] ea [BS];
  logic signed [7:0] eb [BS];
  logic        [7:0] o_scale;
  logic        [7:0] o_el [BS];
  logic              o_overflow, o_is_unused;
  logic        [9:0] nshift;
  logic signed [23:0] tsum [BS];
  logic        [23:0] mabs;
  logic signed [23:0] at [BS];
  logic signed [23:0] bt [BS];

  int n_checks = 0;
  int n_fail   = 0;

  mxint8_add #(.BLOCK_SIZE(BS), .ELEM_W(8), .SCALE_W(8)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .i_scale_a                (sa),
    .i_scale_b                (sb),
    .i_mxint8_elements_a      (ea),
    .i_mxint8_elements_b      (eb),
    .o_scale                  (o_scale),
    .o_mxint8_elements        (o_el),
    .o_overflow               (o_overflow),
    .o_is_unused              (o_is_unused),
    .normalize_shift          (nshift),
    .temp_add_result          (tsum),
    .max_abs_value            (mabs),
    .i_mxint8_elements_a_temp (at),
    .i_mxint8_elements_b_temp (bt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a_s, input logic [7:0] b_s,
                       input logic [7:0] a_v, input logic [7:0] b_v);
    sa = a_s;
    sb = b_s;
    for (int i = 0; i < BS; i++) begin
      ea[i] = a_v;
      eb[i] = b_v;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic [7:0] scale,
                             input logic ovf, input logic unused);
    check_eq({tag, "_scale"}, o_scale, scale);
    check_eq({tag, "_ovf"}, o_overflow, ovf);
    check_eq({tag, "_unused"}, o_is_unused, unused);
  endtask

  initial begin
    rst = 1'b1;
    drive(8'd127, 8'd127, 8'h10, 8'h20);
    #3;
    check_eq("rst0_scale", o_scale, 0);
    check_eq("rst0_el0", o_el[0], 0);
    check_eq("rst0_tsum", tsum[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Plain sum at equal scales
    step();
    check_flags("basic", 8'd127, 1'b0, 1'b0);
    check_eq("basic_el0", o_el[0], 8'h30);
    check_eq("basic_el31", o_el[BS-1], 8'h30);
    check_eq("basic_shift", nshift, 0);
    check_eq("basic_mabs", mabs, 48);

    // Mid-stream async reset, then recovery
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_scale", o_scale, 0);
    check_eq("rst_el0", o_el[0], 0);
    check_eq("rst_mabs", mabs, 0);
    check_eq("rst_at", at[0], 0);
    @(negedge clk);
    rst = 1'b0;
    drive(8'd127, 8'd127, 8'h7F, 8'h7F);
    step();
    check_flags("pmax", 8'd128, 1'b0, 1'b0);
    check_eq("pmax_tsum", tsum[3], 254);
    check_eq("pmax_mabs", mabs, 254);
    check_eq("pmax_shift", nshift, 1);
    check_eq("pmax_el", o_el[3], 8'h7F);

    @(negedge clk);
    drive(8'd127, 8'd127, 8'h80, 8'h80);
    step();
    check_flags("nmax", 8'd128, 1'b0, 1'b0);
    check_eq("nmax_tsum", tsum[7], -256);
    check_eq("nmax_mabs", mabs, 255);
    check_eq("nmax_shift", nshift, 1);
    check_eq("nmax_el", o_el[7], 8'h80);

    @(negedge clk);
    drive(8'd130, 8'd128, 8'h01, 8'h04);
    step();
    check_flags("align", 8'd128, 1'b0, 1'b0);
    check_eq("align_at", at[0], 4);
    check_eq("align_bt", bt[0], 4);
    check_eq("align_el", o_el[0], 8'h08);

    @(negedge clk);
    drive(8'd200, 8'd100, 8'h40, 8'h7F);
    step();
    check_flags("wide", 8'd200, 1'b0, 1'b0);
    check_eq("wide_at", at[1], 2097152);
    check_eq("wide_bt", bt[1], 0);
    check_eq("wide_shift", nshift, 15);
    check_eq("wide_el", o_el[1], 8'h40);

    // Right-shift of -1 stays -1 (floor); sum 32767 needs k=8
    @(negedge clk);
    drive(8'd100, 8'd130, 8'hFF, 8'h01);
    step();
    check_flags("floor", 8'd123, 1'b0, 1'b0);
    check_eq("floor_at", at[2], -1);
    check_eq("floor_bt", bt[2], 32768);
    check_eq("floor_mabs", mabs, 32767);
    check_eq("floor_shift", nshift, 8);
    check_eq("floor_el", o_el[2], 8'h7F);

    // Per-element pattern: A[i]=i, B[i]=2i -> 3i
    @(negedge clk);
    drive(8'd127, 8'd127, 8'h00, 8'h00);
    for (int i = 0; i < BS; i++) begin
      ea[i] = 8'(i);
      eb[i] = 8'(2 * i);
    end
    step();
    check_flags("pat", 8'd127, 1'b0, 1'b0);
    check_eq("pat_el5", o_el[5], 15);
    check_eq("pat_el31", o_el[31], 93);
    check_eq("pat_mabs", mabs, 93);

    @(negedge clk);
    drive(8'd50, 8'd50, 8'h10, 8'hF0);
    step();
    check_flags("zero", 8'd50, 1'b0, 1'b0);
    check_eq("zero_shift", nshift, 0);
    check_eq("zero_el", o_el[9], 0);

    @(negedge clk);
    drive(8'd254, 8'd254, 8'h7F, 8'h7F);
    step();
    check_flags("ovf", 8'hFF, 1'b1, 1'b0);
    check_eq("ovf_el", o_el[0], 0);

    @(negedge clk);
    drive(8'hFF, 8'd127, 8'h10, 8'h20);
    step();
    check_flags("nan", 8'hFF, 1'b0, 1'b1);
    check_eq("nan_el", o_el[4], 0);

    // NaN on a result that would otherwise overflow
    @(negedge clk);
    drive(8'hFF, 8'd254, 8'h7F, 8'h7F);
    step();
    check_flags("nanovf", 8'hFF, 1'b0, 1'b1);
    check_eq("nanovf_el", o_el[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
